// File: rtl/be_core.sv
// Parametrised accumulator CPU: 16-opcode ISA, FETCH/EXEC/MEM/HALT sequencer and a
// ready-gated single-port memory bus.
module be_core #(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'('hF0)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              halted
);

  localparam logic [3:0] OpAdc = 4'd0;
  localparam logic [3:0] OpSwp = 4'd1;
  localparam logic [3:0] OpLda = 4'd2;
  localparam logic [3:0] OpSta = 4'd3;
  localparam logic [3:0] OpJmp = 4'd4;
  localparam logic [3:0] OpSbc = 4'd5;
  localparam logic [3:0] OpAnd = 4'd6;
  localparam logic [3:0] OpOr  = 4'd7;
  localparam logic [3:0] OpXor = 4'd8;
  localparam logic [3:0] OpRlc = 4'd9;
  localparam logic [3:0] OpClc = 4'd10;
  localparam logic [3:0] OpSec = 4'd11;
  localparam logic [3:0] OpJc  = 4'd12;
  localparam logic [3:0] OpLdi = 4'd13;
  localparam logic [3:0] OpNop = 4'd14;
  localparam logic [3:0] OpHlt = 4'd15;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              c_q, c_d;
  logic [3:0]        ir_q, ir_d;
  logic [DATA_W:0]   sum;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] operand_addr;

  assign pc_inc       = pc_q + ADDR_W'(1);
  assign operand_addr = din[ADDR_W-1:0];

  // ADC and SBC share one adder; SBC feeds the inverted B operand.
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, (ir_q == OpSbc) ? ~b_q : b_q} + {{DATA_W{1'b0}}, c_q};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ir_d    = ir_q;
    if (ready) begin
      unique case (state_q)
        StFetch: begin
          ir_d    = din[3:0];
          pc_d    = pc_inc;
          state_d = StExec;
        end
        StExec: begin
          state_d = StFetch;
          unique case (ir_q)
            OpAdc, OpSbc: {c_d, a_d} = sum;
            OpSwp: begin
              a_d = b_q;
              b_d = a_q;
            end
            OpLda, OpSta: begin
              ar_d    = operand_addr;
              pc_d    = pc_inc;
              state_d = StMem;
            end
            OpJmp: pc_d = operand_addr;
            OpAnd: a_d = a_q & b_q;
            OpOr:  a_d = a_q | b_q;
            OpXor: a_d = a_q ^ b_q;
            OpRlc: {c_d, a_d} = {a_q, c_q};
            OpClc: c_d = 1'b0;
            OpSec: c_d = 1'b1;
            OpJc:  pc_d = c_q ? operand_addr : pc_inc;
            OpLdi: begin
              a_d  = din;
              pc_d = pc_inc;
            end
            OpNop: ;
            OpHlt: state_d = StHalt;
            default: ;
          endcase
        end
        StMem: begin
          if (ir_q == OpLda) a_d = din;
          state_d = StFetch;
        end
        StHalt: ;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ar_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    addr   = (state_q == StMem) ? ar_q : pc_q;
    rw     = (state_q == StMem) && (ir_q == OpSta);
    halted = (state_q == StHalt);
  end

  assign dout  = a_q;
  assign acc   = a_q;
  assign carry = c_q;

endmodule

// File: tb/tb_be_core.sv
// Self-checking bench for be_core: directed scenarios plus random straight-line programs
// compared against an instruction-level reference model.
module tb_be_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ready;
  logic [7:0]  din8, dout8, acc8, addr8;
  logic        rw8, carry8, halted8;
  logic [7:0]  mem8 [256];

  logic        rst16;
  logic        ready16;
  logic [15:0] din16, dout16, acc16;
  logic [11:0] addr16;
  logic        rw16, carry16, halted16;
  logic [15:0] mem16 [4096];

  assign din8    = mem8[addr8];
  assign din16   = mem16[addr16];
  assign ready16 = 1'b1;

  be_core u_dut8 (
    .clk(clk), .rst(rst), .ready(ready), .din(din8), .dout(dout8), .addr(addr8),
    .rw(rw8), .acc(acc8), .carry(carry8), .halted(halted8)
  );

  be_core #(.DATA_W(16), .ADDR_W(12)) u_dut16 (
    .clk(clk), .rst(rst16), .ready(ready16), .din(din16), .dout(dout16), .addr(addr16),
    .rw(rw16), .acc(acc16), .carry(carry16), .halted(halted16)
  );

  int         n_checks, n_errors;
  int         wr_cnt, cyc;
  logic [7:0] wr_addr, wr_data;
  logic [7:0] prog_q [$];
  int         mm [256];
  int         ea, ec, epc, ecyc, ewr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit has_operand(input int op);
    return op == 2 || op == 3 || op == 4 || op == 12 || op == 13;
  endfunction

  // Memory write happens just before the edge at which the DUT leaves MEM.
  task automatic step();
    if (rw8 && ready) begin
      mem8[addr8] = dout8;
      wr_cnt++;
      wr_addr = addr8;
      wr_data = dout8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    ready = 1'b1;
    step();
    rst    = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) mem8[i] = 8'h0F;
    for (int i = 'h80; i < 'h90; i++) mem8[i] = 8'($urandom);
    for (int i = 0; i < prog_q.size(); i++) mem8[(240 + i) % 256] = prog_q[i];
  endtask

  task automatic model_run();
    int a, b, c, pc, op, s, t;
    bit done;
    for (int i = 0; i < 256; i++) mm[i] = int'(mem8[i]);
    a = 0; b = 0; c = 0; pc = 'hF0; ecyc = 0; ewr = 0; done = 0;
    for (int k = 0; k < 500 && !done; k++) begin
      op   = mm[pc] % 16;
      pc   = (pc + 1) % 256;
      ecyc += 2;
      case (op)
        0:  begin s = a + b + c; a = s % 256; c = s / 256; end
        1:  begin t = a; a = b; b = t; end
        2:  begin t = mm[pc]; pc = (pc + 1) % 256; a = mm[t]; ecyc++; end
        3:  begin t = mm[pc]; pc = (pc + 1) % 256; mm[t] = a; ewr++; ecyc++; end
        4:  pc = mm[pc];
        5:  begin s = a + (255 - b) + c; a = s % 256; c = s / 256; end
        6:  a = a & b;
        7:  a = a | b;
        8:  a = a ^ b;
        9:  begin s = a * 2 + c; a = s % 256; c = s / 256; end
        10: c = 0;
        11: c = 1;
        12: pc = c ? mm[pc] : (pc + 1) % 256;
        13: begin a = mm[pc]; pc = (pc + 1) % 256; end
        15: done = 1;
        default: ;
      endcase
    end
    ea = a; ec = c; epc = pc;
  endtask

  task automatic gen_random();
    int n, pos;
    int ops [$];
    int offs [$];
    logic [7:0] w;
    n = $urandom_range(4, 18);
    pos = 0;
    for (int i = 0; i < n; i++) begin
      ops.push_back($urandom_range(0, 14));
      offs.push_back(pos);
      pos += has_operand(ops[i]) ? 2 : 1;
    end
    ops.push_back(15);
    offs.push_back(pos);
    prog_q = {};
    for (int i = 0; i <= n; i++) begin
      w = {4'($urandom), 4'(ops[i])};
      prog_q.push_back(w);
      if (has_operand(ops[i])) begin
        case (ops[i])
          2, 3:    w = 8'h80 | 8'($urandom_range(0, 15));
          4, 12:   w = 8'(240 + offs[$urandom_range(i + 1, n)]);
          default: w = 8'($urandom);
        endcase
        prog_q.push_back(w);
      end
    end
  endtask

  // Runs mem8 from reset to HLT and compares against the reference model.
  task automatic run_prog(input bit stall);
    int n;
    model_run();
    do_reset();
    cyc = 0;
    n = 0;
    while (!halted8 && n < 3000) begin
      ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ready) cyc++;
      step();
      n++;
    end
    ready = 1'b1;
    check_eq("halt_reached", halted8, 1);
    check_eq("acc", acc8, ea);
    check_eq("carry", carry8, ec);
    check_eq("pc", addr8, epc);
    check_eq("cycles", cyc, ecyc);
    check_eq("writes", wr_cnt, ewr);
    for (int i = 'h80; i < 'h90; i++) check_eq("mem", mem8[i], mm[i]);
  endtask

  task automatic wait_rw();
    int n;
    n = 0;
    while (!rw8 && n < 20) begin
      step();
      n++;
    end
    check_eq("sta_reached", rw8, 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    rst16    = 1'b1;
    ready    = 1'b1;
    wr_cnt   = 0;

    // Reset state and NOP/HLT latency.
    prog_q = '{8'h0E, 8'h0F};
    load_prog();
    do_reset();
    check_eq("rst_addr", addr8, 8'hF0);
    check_eq("rst_rw", rw8, 0);
    check_eq("rst_halted", halted8, 0);
    check_eq("rst_dout", dout8, 0);
    check_eq("rst_acc", acc8, 0);
    check_eq("rst_carry", carry8, 0);
    step(); step();
    check_eq("nop_addr", addr8, 8'hF1);
    check_eq("nop_halted", halted8, 0);
    step(); step();
    check_eq("hlt_latency", halted8, 1);

    // ADC overflow and SBC without borrow.
    prog_q = '{8'h0D, 8'hFF, 8'h01, 8'h0D, 8'h01, 8'h00, 8'h0F};
    load_prog();
    run_prog(0);
    check_eq("adc_a", acc8, 8'h00);
    check_eq("adc_c", carry8, 1);
    prog_q = '{8'h0D, 8'h03, 8'h01, 8'h0D, 8'h05, 8'h0B, 8'h05, 8'h0F};
    load_prog();
    run_prog(0);
    check_eq("sbc_a", acc8, 8'h02);
    check_eq("sbc_c", carry8, 1);

    // Store then load back.
    prog_q = '{8'h0D, 8'h5A, 8'h03, 8'h10, 8'h0D, 8'h00, 8'h02, 8'h10, 8'h0F};
    load_prog();
    run_prog(0);
    check_eq("lda_a", acc8, 8'h5A);
    check_eq("sta_cnt", wr_cnt, 1);
    check_eq("sta_addr", wr_addr, 8'h10);
    check_eq("sta_data", wr_data, 8'h5A);
    check_eq("mem_cycles", cyc, 12);

    // Conditional jump, not taken then taken.
    prog_q = '{8'h0A, 8'h0C, 8'h20, 8'h0D, 8'h77, 8'h0F};
    load_prog();
    mem8[8'h20] = 8'h0D; mem8[8'h21] = 8'h99; mem8[8'h22] = 8'h0F;
    run_prog(0);
    check_eq("jc_fall_a", acc8, 8'h77);
    check_eq("jc_fall_pc", addr8, 8'hF6);
    prog_q = '{8'h0B, 8'h0C, 8'h20, 8'h0D, 8'h77, 8'h0F};
    load_prog();
    mem8[8'h20] = 8'h0D; mem8[8'h21] = 8'h99; mem8[8'h22] = 8'h0F;
    run_prog(0);
    check_eq("jc_take_a", acc8, 8'h99);
    check_eq("jc_take_pc", addr8, 8'h23);

    // JMP from the top of the address space; code also wraps past FF.
    prog_q = {};
    for (int i = 0; i < 14; i++) prog_q.push_back(8'h0E);
    prog_q.push_back(8'h04);
    prog_q.push_back(8'h00);
    prog_q.push_back(8'h0D);
    prog_q.push_back(8'h42);
    prog_q.push_back(8'h0F);
    load_prog();
    run_prog(0);
    check_eq("jmp_wrap_a", acc8, 8'h42);
    check_eq("jmp_wrap_pc", addr8, 8'h03);

    // Wait states during STA.
    prog_q = '{8'h0D, 8'h5A, 8'h03, 8'h10, 8'h0F};
    load_prog();
    do_reset();
    wait_rw();
    check_eq("ws_addr", addr8, 8'h10);
    check_eq("ws_dout", dout8, 8'h5A);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("ws_rw", rw8, 1);
      check_eq("ws_addr", addr8, 8'h10);
      check_eq("ws_dout", dout8, 8'h5A);
    end
    ready = 1'b1;
    step();
    check_eq("ws_rw_drop", rw8, 0);
    check_eq("ws_writes", wr_cnt, 1);
    check_eq("ws_mem", mem8[8'h10], 8'h5A);

    // Reset while stalled in MEM of STA.
    load_prog();
    do_reset();
    wait_rw();
    ready = 1'b0;
    rst   = 1'b1;
    step();
    check_eq("rst_sta_rw", rw8, 0);
    check_eq("rst_sta_addr", addr8, 8'hF0);
    check_eq("rst_sta_writes", wr_cnt, 0);
    rst   = 1'b0;
    ready = 1'b1;

    // HALT holds regardless of ready; only reset exits.
    prog_q = '{8'h0F};
    load_prog();
    run_prog(0);
    for (int k = 0; k < 20; k++) begin
      ready = 1'($urandom);
      step();
      check_eq("halt_hold", halted8, 1);
      check_eq("halt_addr", addr8, 8'hF1);
      check_eq("halt_rw", rw8, 0);
    end
    ready = 1'b1;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    check_eq("halt_exit", halted8, 0);
    check_eq("halt_exit_addr", addr8, 8'hF0);

    // Random programs, alternating full speed and random wait states.
    for (int r = 0; r < 30; r++) begin
      gen_random();
      load_prog();
      run_prog(r[0]);
    end

    // 16-bit data / 12-bit address instance.
    for (int i = 0; i < 4096; i++) mem16[i] = 16'h000F;
    mem16[12'h0F0] = 16'h000D; mem16[12'h0F1] = 16'hFFFF; mem16[12'h0F2] = 16'h0001;
    mem16[12'h0F3] = 16'h000D; mem16[12'h0F4] = 16'h0001; mem16[12'h0F5] = 16'h0000;
    mem16[12'h0F6] = 16'h000F;
    rst16 = 1'b1;
    step();
    rst16 = 1'b0;
    check_eq("w16_rst_addr", addr16, 12'h0F0);
    for (int k = 0; k < 50 && !halted16; k++) step();
    check_eq("w16_halted", halted16, 1);
    check_eq("w16_a", acc16, 16'h0000);
    check_eq("w16_c", carry16, 1);
    check_eq("w16_pc", addr16, 12'h0F7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
